j68_useq: RTL and testbench

- Microcode sequencer for the j68 core; the stage directly upstream of the hardware loop unit.
- Owns the micro-PC and computes the next microcode ROM address every enabled cycle.
- Drives `pc_in` and `i_fetch` to the loop unit and consumes its `branch`, `skip` and loop-start PC.
- Implements jump, conditional jump, call/return with a small return stack, decode dispatch, exception entry and stall hold.

---
 rtl/j68_pkg.sv | 34 +++
 rtl/j68_useq_if.sv | 33 +++
 rtl/j68_ustack.sv | 71 +++++++
 rtl/j68_useq.sv | 102 ++++++++++
 tb/tb_j68_useq.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/j68_pkg.sv
// Shared widths, field positions and opcode classes for the j68 microcode sequencer.
package j68_pkg;

    localparam int UPC_W  = 11;
    localparam int INST_W = 20;

    localparam int ADDR_LSB  = 0;
    localparam int ADDR_MSB  = 10;
    localparam int LOOPT_BIT = 11;
    localparam int COND_LSB  = 12;
    localparam int COND_MSB  = 15;
    localparam int CINV_BIT  = 16;
    localparam int OP_LSB    = 17;
    localparam int OP_MSB    = 19;

    localparam logic [2:0] OP_LOOP = 3'b000;
    localparam logic [2:0] OP_JMP  = 3'b001;
    localparam logic [2:0] OP_CALL = 3'b010;
    localparam logic [2:0] OP_RET  = 3'b011;

    typedef logic [UPC_W-1:0] upc_t;

    typedef enum logic [1:0] {
        RS_NONE  = 2'd0,
        RS_PUSH  = 2'd1,
        RS_POP   = 2'd2,
        RS_CLEAR = 2'd3
    } rs_op_e;

    function automatic upc_t upc_inc(input upc_t pc);
        return upc_t'(pc + upc_t'(1));
    endfunction

endpackage

// File: rtl/j68_useq_if.sv
// Sequencer-side bus: ROM, condition, dispatch, exception and loop-unit signals.
interface j68_useq_if;
    import j68_pkg::*;

    logic                 clk_ena;
    logic                 stall;
    logic [INST_W-1:0]    inst_in;
    logic [15:0]          flags;
    upc_t                 dec_addr;
    logic                 exc_req;
    upc_t                 exc_vec;
    logic                 loop_branch;
    logic                 loop_skip;
    upc_t                 loop_pc;
    upc_t                 rom_addr;
    upc_t                 upc;
    logic                 i_fetch;
    logic                 exec_ena;
    logic                 rs_ovf;

    modport master (
        output clk_ena, stall, inst_in, flags, dec_addr, exc_req, exc_vec,
               loop_branch, loop_skip, loop_pc,
        input  rom_addr, upc, i_fetch, exec_ena, rs_ovf
    );

    modport slave (
        input  clk_ena, stall, inst_in, flags, dec_addr, exc_req, exc_vec,
               loop_branch, loop_skip, loop_pc,
        output rom_addr, upc, i_fetch, exec_ena, rs_ovf
    );

endinterface

// File: rtl/j68_ustack.sv
// Circular return stack: a full push overwrites the oldest entry, an empty pop
// reads the wrapped slot; either case raises the sticky ovf flag.
module j68_ustack
    import j68_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  rs_op_e op,
    input  upc_t   push_data,
    output upc_t   pop_data,
    output logic   ovf
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_dec;
    logic [PW:0]   cnt_q;
    logic          ovf_q;
    upc_t          mem_q [DEPTH];

    assign ptr_dec  = ptr_q - PW'(1);
    assign pop_data = mem_q[ptr_dec];
    assign ovf      = ovf_q;

    // Entries are reset so an underflowing pop returns a defined address.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                mem_q[gi] <= '0;
            end else if (op == RS_PUSH && ptr_q == PW'(gi)) begin
                mem_q[gi] <= push_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            case (op)
                RS_PUSH: begin
                    ptr_q <= ptr_q + PW'(1);
                    if (cnt_q == (PW+1)'(DEPTH)) begin
                        ovf_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + (PW+1)'(1);
                    end
                end
                RS_POP: begin
                    ptr_q <= ptr_dec;
                    if (cnt_q == '0) begin
                        ovf_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - (PW+1)'(1);
                    end
                end
                RS_CLEAR: begin
                    ptr_q <= '0;
                    cnt_q <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/j68_useq.sv
// j68 microcode sequencer: owns the micro-PC and produces the next ROM address
// combinationally so taken jumps cost no bubble.
module j68_useq
    import j68_pkg::*;
#(
    parameter int   RS_DEPTH = 4,
    parameter upc_t RST_VEC  = 11'd0
) (
    input  logic clk,
    input  logic rst,
    j68_useq_if.slave bus
);

    upc_t   upc_q;
    logic   squash_q;
    logic   squash_d;
    upc_t   rom_addr_d;
    upc_t   upc_next;
    upc_t   tgt;
    upc_t   pop_data;
    rs_op_e rs_op;
    logic   hold;
    logic   fetch;
    logic   cond_taken;
    logic   rs_ovf;
    logic [2:0] opc;

    assign hold       = bus.stall | ~bus.clk_ena;
    assign fetch      = ~hold & ~squash_q;
    assign upc_next   = upc_inc(upc_q);
    assign opc        = bus.inst_in[OP_MSB:OP_LSB];
    assign tgt        = bus.inst_in[ADDR_MSB:ADDR_LSB];
    assign cond_taken = bus.flags[bus.inst_in[COND_MSB:COND_LSB]] ^ bus.inst_in[CINV_BIT];

    always_comb begin
        rom_addr_d = upc_next;
        squash_d   = 1'b0;
        rs_op      = RS_NONE;
        if (rst) begin
            rom_addr_d = RST_VEC;
        end else if (hold) begin
            rom_addr_d = upc_q;
            squash_d   = squash_q;
        end else if (bus.exc_req) begin
            rom_addr_d = bus.exc_vec;
            squash_d   = 1'b1;
            rs_op      = RS_CLEAR;
        end else if (bus.loop_branch) begin
            rom_addr_d = bus.loop_pc;
            squash_d   = 1'b1;
        end else if (!squash_q) begin
            case (opc)
                OP_LOOP: begin
                    if (bus.loop_skip) rom_addr_d = upc_inc(tgt);
                end
                OP_JMP: begin
                    if (cond_taken) rom_addr_d = tgt;
                end
                OP_CALL: begin
                    rom_addr_d = tgt;
                    rs_op      = RS_PUSH;
                end
                OP_RET: begin
                    // LOOPT bit doubles as the RET/DISPATCH selector here.
                    if (bus.inst_in[LOOPT_BIT]) begin
                        rom_addr_d = bus.dec_addr;
                    end else begin
                        rom_addr_d = pop_data;
                        rs_op      = RS_POP;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upc_q    <= RST_VEC;
            squash_q <= 1'b1;
        end else if (!hold) begin
            upc_q    <= rom_addr_d;
            squash_q <= squash_d;
        end
    end

    j68_ustack #(.DEPTH(RS_DEPTH)) u_stack (
        .clk       (clk),
        .rst       (rst),
        .op        (rs_op),
        .push_data (upc_next),
        .pop_data  (pop_data),
        .ovf       (rs_ovf)
    );

    assign bus.rom_addr = rom_addr_d;
    assign bus.upc      = upc_q;
    assign bus.i_fetch  = fetch;
    assign bus.exec_ena = fetch;
    assign bus.rs_ovf   = rs_ovf;

endmodule

// File: tb/tb_j68_useq.sv
// Directed bench for j68_useq: the driver queues expected outputs, a negedge
// monitor pops and compares them.
module tb_j68_useq;
    import j68_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    j68_useq_if bus();

    j68_useq #(.RS_DEPTH(4), .RST_VEC(11'd0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int         step;
        logic       chk_ra;
        logic [10:0] ra;
        logic [10:0] pc;
        logic       f;
        logic       ovf;
    } exp_t;

    exp_t sb_q[$];
    exp_t cur;
    int   total = 0;
    int   bad   = 0;
    int   step  = 0;

    localparam logic [19:0] DP   = 20'h80000;
    localparam logic [19:0] RET  = {3'b011, 6'b0, 11'h000};
    localparam logic [19:0] DISP = {3'b011, 5'b0, 1'b1, 11'h000};
    localparam logic [19:0] LOOPI = 20'h0080C;

    function automatic logic [19:0] jmp(input logic inv, input logic [3:0] c, input logic [10:0] t);
        return {3'b001, inv, c, 1'b0, t};
    endfunction

    function automatic logic [19:0] call(input logic [10:0] t);
        return {3'b010, 6'b0, t};
    endfunction

    task automatic expect_out(input logic chk_ra, input logic [10:0] ra, input logic [10:0] pc,
                              input logic f, input logic ovf);
        exp_t e;
        e.step = step; e.chk_ra = chk_ra; e.ra = ra; e.pc = pc; e.f = f; e.ovf = ovf;
        sb_q.push_back(e);
        step++;
    endtask

    task automatic chk(input string name, input int s, input logic [10:0] got, input logic [10:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL step=%0d %s got=%h want=%h", s, name, got, want);
        end
    endtask

    // Advance to just after the next rising edge and return pulse inputs to idle.
    task automatic nxt();
        @(posedge clk);
        #1;
        bus.clk_ena     = 1'b1;
        bus.stall       = 1'b0;
        bus.exc_req     = 1'b0;
        bus.loop_branch = 1'b0;
        bus.loop_skip   = 1'b0;
        bus.inst_in     = DP;
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            cur = sb_q.pop_front();
            $display("step %0d: upc=%h rom_addr=%h i_fetch=%b exec_ena=%b rs_ovf=%b",
                     cur.step, bus.upc, bus.rom_addr, bus.i_fetch, bus.exec_ena, bus.rs_ovf);
            if (cur.chk_ra) chk("rom_addr", cur.step, bus.rom_addr, cur.ra);
            chk("upc", cur.step, bus.upc, cur.pc);
            chk("i_fetch", cur.step, {10'b0, bus.i_fetch}, {10'b0, cur.f});
            chk("exec_ena", cur.step, {10'b0, bus.exec_ena}, {10'b0, cur.f});
            chk("rs_ovf", cur.step, {10'b0, bus.rs_ovf}, {10'b0, cur.ovf});
        end
    end

    initial begin
        bus.clk_ena = 1'b1; bus.stall = 1'b0; bus.inst_in = DP; bus.flags = 16'h0001;
        bus.dec_addr = 11'h000; bus.exc_req = 1'b0; bus.exc_vec = 11'h000;
        bus.loop_branch = 1'b0; bus.loop_skip = 1'b0; bus.loop_pc = 11'h000;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1 expect_out(1, 11'h000, 11'h000, 0, 0);
        nxt(); nxt();
        rst = 1'b0;                                     expect_out(1, 11'h001, 11'h000, 0, 0);
        nxt();                                          expect_out(1, 11'h002, 11'h001, 1, 0);
        nxt();                                          expect_out(1, 11'h003, 11'h002, 1, 0);
        nxt();                                          expect_out(1, 11'h004, 11'h003, 1, 0);
        nxt(); bus.inst_in = jmp(0, 0, 11'h010);        expect_out(1, 11'h010, 11'h004, 1, 0);
        nxt(); bus.inst_in = jmp(0, 3, 11'h155);        expect_out(1, 11'h011, 11'h010, 1, 0);
        nxt(); bus.flags = 16'h0009; bus.inst_in = jmp(0, 3, 11'h155);
                                                        expect_out(1, 11'h155, 11'h011, 1, 0);
        nxt(); bus.inst_in = jmp(1, 3, 11'h155);        expect_out(1, 11'h156, 11'h155, 1, 0);
        nxt(); bus.inst_in = jmp(0, 0, 11'h020);        expect_out(1, 11'h020, 11'h156, 1, 0);
        nxt(); bus.inst_in = call(11'h200);             expect_out(1, 11'h200, 11'h020, 1, 0);
        nxt(); bus.inst_in = RET;                       expect_out(1, 11'h021, 11'h200, 1, 0);
        nxt(); bus.inst_in = DISP; bus.dec_addr = 11'h3AB;
                                                        expect_out(1, 11'h3AB, 11'h021, 1, 0);
        nxt(); bus.inst_in = jmp(0, 0, 11'h005);        expect_out(1, 11'h005, 11'h3AB, 1, 0);
        nxt(); bus.inst_in = LOOPI; bus.loop_skip = 1;  expect_out(1, 11'h00D, 11'h005, 1, 0);
        nxt(); bus.inst_in = LOOPI;                     expect_out(1, 11'h00E, 11'h00D, 1, 0);
        nxt(); bus.inst_in = call(11'h300); bus.loop_branch = 1; bus.loop_pc = 11'h006;
                                                        expect_out(1, 11'h006, 11'h00E, 1, 0);
        nxt();                                          expect_out(1, 11'h007, 11'h006, 0, 0);
        nxt();                                          expect_out(1, 11'h008, 11'h007, 1, 0);
        nxt(); bus.inst_in = call(11'h100);             expect_out(1, 11'h100, 11'h008, 1, 0);
        nxt(); bus.inst_in = call(11'h300); bus.loop_branch = 1; bus.loop_pc = 11'h050;
                                                        expect_out(1, 11'h050, 11'h100, 1, 0);
        nxt(); bus.inst_in = RET;                       expect_out(1, 11'h051, 11'h050, 0, 0);
        nxt(); bus.inst_in = RET;                       expect_out(1, 11'h009, 11'h051, 1, 0);
        nxt(); bus.inst_in = call(11'h040);             expect_out(1, 11'h040, 11'h009, 1, 0);
        nxt(); bus.stall = 1; bus.inst_in = call(11'h123);
                                                        expect_out(1, 11'h040, 11'h040, 0, 0);
        nxt(); bus.stall = 1; bus.exc_req = 1; bus.exc_vec = 11'h7F0; bus.inst_in = call(11'h123);
                                                        expect_out(1, 11'h040, 11'h040, 0, 0);
        nxt(); bus.stall = 1; bus.exc_req = 1; bus.inst_in = call(11'h123);
                                                        expect_out(1, 11'h040, 11'h040, 0, 0);
        nxt(); bus.exc_req = 1; bus.inst_in = call(11'h123);
                                                        expect_out(1, 11'h7F0, 11'h040, 1, 0);
        nxt();                                          expect_out(1, 11'h7F1, 11'h7F0, 0, 0);
        nxt(); bus.inst_in = RET;                       expect_out(1, 11'h000, 11'h7F1, 1, 0);
        nxt(); bus.inst_in = call(11'h333);             expect_out(1, 11'h333, 11'h000, 1, 1);
        nxt(); bus.inst_in = call(11'h444); bus.loop_branch = 1; rst = 1'b1;
                                                        expect_out(1, 11'h000, 11'h000, 0, 0);
        nxt(); rst = 1'b0;                              expect_out(1, 11'h001, 11'h000, 0, 0);
        nxt(); bus.inst_in = RET;                       expect_out(1, 11'h000, 11'h001, 1, 0);
        nxt();                                          expect_out(1, 11'h001, 11'h000, 1, 1);
        nxt(); rst = 1'b1;                              expect_out(1, 11'h000, 11'h000, 0, 0);
        nxt(); rst = 1'b0;                              expect_out(1, 11'h001, 11'h000, 0, 0);
        nxt(); bus.inst_in = call(11'h010);             expect_out(1, 11'h010, 11'h001, 1, 0);
        nxt(); bus.inst_in = call(11'h020);             expect_out(1, 11'h020, 11'h010, 1, 0);
        nxt(); bus.inst_in = call(11'h030);             expect_out(1, 11'h030, 11'h020, 1, 0);
        nxt(); bus.inst_in = call(11'h040);             expect_out(1, 11'h040, 11'h030, 1, 0);
        nxt(); bus.inst_in = call(11'h050);             expect_out(1, 11'h050, 11'h040, 1, 0);
        nxt();                                          expect_out(1, 11'h051, 11'h050, 1, 1);
        nxt(); bus.inst_in = RET;                       expect_out(1, 11'h041, 11'h051, 1, 1);
        nxt(); bus.inst_in = jmp(0, 0, 11'h7FF);        expect_out(1, 11'h7FF, 11'h041, 1, 1);
        nxt();                                          expect_out(1, 11'h000, 11'h7FF, 1, 1);
        nxt();                                          expect_out(1, 11'h001, 11'h000, 1, 1);
        nxt(); bus.clk_ena = 1'b0;                      expect_out(0, 11'h000, 11'h001, 0, 1);
        nxt();                                          expect_out(1, 11'h002, 11'h001, 1, 1);
        nxt();
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
        if (sb_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain got=%0d pending want=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
